reg_writeback_ctrl: RTL and testbench

- Write-side controller for the 8x32 register file.
- Accepts register-write results from the ALU and the instruction decoder (ID) over valid/ready handshakes, and buffers them in an in-order queue.
- Drives the register file write port: write_addr, write_value_alu, write_value_id, write_data_sel, write_enable.
- Exports a pending-write mask so issue logic can detect RAW hazards on registers with writes still in flight.

---
 rtl/reg_writeback_ctrl_if.sv | 47 ++++
 rtl/reg_writeback_ctrl.sv | 115 +++++++++++
 tb/tb_reg_writeback_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_ctrl_if.sv
// rtl/reg_writeback_ctrl_if.sv - handshake and register-file write bundle for reg_writeback_ctrl
// Forwarding lookup signals exist only when WB_FORWARD_EN is defined.
interface reg_writeback_ctrl_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_addr;
  logic [31:0] alu_value;
  logic        id_valid;
  logic        id_ready;
  logic [2:0]  id_addr;
  logic [31:0] id_value;
  logic        wb_stall;
  logic [2:0]  write_addr;
  logic [31:0] write_value_alu;
  logic [31:0] write_value_id;
  logic        write_data_sel;
  logic        write_enable;
  logic [7:0]  pending_mask;
  logic        busy;
`ifdef WB_FORWARD_EN
  logic [2:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_value;

  modport master (
    output alu_valid, alu_addr, alu_value, id_valid, id_addr, id_value, wb_stall, fwd_addr,
    input  alu_ready, id_ready, write_addr, write_value_alu, write_value_id,
           write_data_sel, write_enable, pending_mask, busy, fwd_hit, fwd_value
  );
  modport slave (
    input  alu_valid, alu_addr, alu_value, id_valid, id_addr, id_value, wb_stall, fwd_addr,
    output alu_ready, id_ready, write_addr, write_value_alu, write_value_id,
           write_data_sel, write_enable, pending_mask, busy, fwd_hit, fwd_value
  );
`else
  modport master (
    output alu_valid, alu_addr, alu_value, id_valid, id_addr, id_value, wb_stall,
    input  alu_ready, id_ready, write_addr, write_value_alu, write_value_id,
           write_data_sel, write_enable, pending_mask, busy
  );
  modport slave (
    input  alu_valid, alu_addr, alu_value, id_valid, id_addr, id_value, wb_stall,
    output alu_ready, id_ready, write_addr, write_value_alu, write_value_id,
           write_data_sel, write_enable, pending_mask, busy
  );
`endif
endinterface

// File: rtl/reg_writeback_ctrl.sv
// rtl/reg_writeback_ctrl.sv - in-order register-file write queue fed by ALU and ID sources
// Define WB_FORWARD_EN to add the combinational forwarding lookup (fwd_addr/fwd_hit/fwd_value).
module reg_writeback_ctrl #(
  parameter int         DEPTH    = 4,
  parameter logic [2:0] ZERO_REG = 3'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_writeback_ctrl_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          rr_alu;

  logic          q_sel   [DEPTH];
  logic [2:0]    q_addr  [DEPTH];
  logic [31:0]   q_value [DEPTH];

  logic          has_space;
  logic          conflict;
  logic          grant_alu;
  logic          grant_id;
  logic          alu_take;
  logic          id_take;
  logic          take;
  logic [2:0]    in_addr;
  logic [31:0]   in_value;
  logic          push;
  logic          pop;

  assign has_space = (count < CW'(DEPTH)) && !rst;
  assign conflict  = bus.alu_valid && bus.id_valid;
  // With nothing offered the grant parks on the ALU so an idle ALU still sees ready.
  assign grant_alu = conflict ? rr_alu  : !bus.id_valid;
  assign grant_id  = conflict ? !rr_alu : bus.id_valid;

  assign bus.alu_ready = has_space && grant_alu;
  assign bus.id_ready  = has_space && grant_id;

  assign alu_take = bus.alu_valid && bus.alu_ready;
  assign id_take  = bus.id_valid && bus.id_ready;
  assign take     = alu_take || id_take;
  assign in_addr  = alu_take ? bus.alu_addr  : bus.id_addr;
  assign in_value = alu_take ? bus.alu_value : bus.id_value;
  assign push     = take && (in_addr != ZERO_REG);

  assign bus.busy         = (count != '0);
  assign bus.write_enable = bus.busy && !bus.wb_stall;
  assign pop              = bus.write_enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      rr_alu <= 1'b1;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (conflict && take) rr_alu <= id_take;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_sel[tail]   <= alu_take;
      q_addr[tail]  <= in_addr;
      q_value[tail] <= in_value;
    end
  end

  logic [PW-1:0] idx;

  always_comb begin
    bus.write_addr      = 3'd0;
    bus.write_data_sel  = 1'b0;
    bus.write_value_alu = 32'd0;
    bus.write_value_id  = 32'd0;
    bus.pending_mask    = 8'd0;
    idx                 = head;
    if (bus.busy) begin
      bus.write_addr     = q_addr[head];
      bus.write_data_sel = q_sel[head];
      if (q_sel[head]) bus.write_value_alu = q_value[head];
      else             bus.write_value_id  = q_value[head];
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) bus.pending_mask[q_addr[idx]] = 1'b1;
    end
  end

`ifdef WB_FORWARD_EN
  logic [PW-1:0] fidx;

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    bus.fwd_hit   = 1'b0;
    bus.fwd_value = 32'd0;
    fidx          = head;
    for (int i = 0; i < DEPTH; i++) begin
      fidx = head + PW'(i);
      if ((CW'(i) < count) && (q_addr[fidx] == bus.fwd_addr) && (bus.fwd_addr != ZERO_REG)) begin
        bus.fwd_hit   = 1'b1;
        bus.fwd_value = q_value[fidx];
      end
    end
  end
`endif
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb/tb_reg_writeback_ctrl.sv - scoreboard bench for reg_writeback_ctrl
module tb_reg_writeback_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_writeback_ctrl_if bus();

  reg_writeback_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        sel;
    logic [2:0]  addr;
    logic [31:0] value;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic sel, input logic [2:0] addr, input logic [31:0] value);
    wr_t e;
    e.sel   = sel;
    e.addr  = addr;
    e.value = value;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.write_enable) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0d, expected no write at %0t", bus.write_addr, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wb_addr", 32'(bus.write_addr), 32'(e.addr));
        check("wb_sel", 32'(bus.write_data_sel), 32'(e.sel));
        check("wb_value_alu", bus.write_value_alu, e.sel ? e.value : 32'd0);
        check("wb_value_id", bus.write_value_id, e.sel ? 32'd0 : e.value);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 3'd1;
    bus.alu_value = 32'hA1A1_A1A1;
    bus.id_valid  = 1'b1;
    bus.id_addr   = 3'd2;
    bus.id_value  = 32'h1D1D_1D1D;
    bus.wb_stall  = 1'b0;
`ifdef WB_FORWARD_EN
    bus.fwd_addr  = 3'd0;
`endif
    repeat (2) tick;
    rst = 1'b0;

    // Reset state, then continuous conflict: ALU, ID, ALU, ID.
    expect_wr(1'b1, 3'd1, 32'hA1A1_A1A1);
    expect_wr(1'b0, 3'd2, 32'h1D1D_1D1D);
    expect_wr(1'b1, 3'd1, 32'hA1A1_A1A1);
    expect_wr(1'b0, 3'd2, 32'h1D1D_1D1D);
    @(negedge clk);
    check("rst_write_enable", 32'(bus.write_enable), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pending_mask", 32'(bus.pending_mask), 32'h00);
    check("rst_write_addr", 32'(bus.write_addr), 32'd0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      check("rr_alu_ready", 32'(bus.alu_ready), (c % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_id_ready", 32'(bus.id_ready), (c % 2 == 0) ? 32'd0 : 32'd1);
      if (c > 0) check("rr_pending", 32'(bus.pending_mask), (c % 2 == 1) ? 32'h02 : 32'h04);
      tick;
    end
    bus.alu_valid = 1'b0;
    bus.id_valid  = 1'b0;
    repeat (3) tick;
    @(negedge clk);
    check("rr_drained_busy", 32'(bus.busy), 32'd0);

    // Single ALU write latency.
    tick;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 3'd3;
    bus.alu_value = 32'hDEAD_BEEF;
    expect_wr(1'b1, 3'd3, 32'hDEAD_BEEF);
    tick;
    bus.alu_valid = 1'b0;
    @(negedge clk);
    check("single_we", 32'(bus.write_enable), 32'd1);
    check("single_addr", 32'(bus.write_addr), 32'd3);
    check("single_sel", 32'(bus.write_data_sel), 32'd1);
    check("single_alu_val", bus.write_value_alu, 32'hDEAD_BEEF);
    check("single_id_val", bus.write_value_id, 32'd0);
    check("single_pending", 32'(bus.pending_mask), 32'h08);
    tick;
    @(negedge clk);
    check("single_idle_we", 32'(bus.write_enable), 32'd0);
    check("single_idle_busy", 32'(bus.busy), 32'd0);

    // Full queue under stall, then release.
    tick;
    bus.wb_stall  = 1'b1;
    bus.alu_valid = 1'b1;
    for (int a = 1; a <= 4; a++) begin
      bus.alu_addr  = 3'(a);
      bus.alu_value = 32'h100 + 32'(a);
      expect_wr(1'b1, 3'(a), 32'h100 + 32'(a));
      tick;
    end
    bus.alu_addr  = 3'd5;
    bus.alu_value = 32'h105;
    expect_wr(1'b1, 3'd5, 32'h105);
    @(negedge clk);
    check("full_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("full_pending", 32'(bus.pending_mask), 32'h1E);
    check("full_busy", 32'(bus.busy), 32'd1);
    check("full_we", 32'(bus.write_enable), 32'd0);
    tick;
    bus.wb_stall = 1'b0;
    @(negedge clk);
    check("full_drain_we", 32'(bus.write_enable), 32'd1);
    check("full_drain_ready", 32'(bus.alu_ready), 32'd0);
    tick;
    @(negedge clk);
    check("after_pop_ready", 32'(bus.alu_ready), 32'd1);
    tick;
    bus.alu_valid = 1'b0;
    repeat (5) tick;
    @(negedge clk);
    check("full_drained_busy", 32'(bus.busy), 32'd0);

    // Zero register: handshake only.
    tick;
    bus.id_valid = 1'b1;
    bus.id_addr  = 3'd0;
    bus.id_value = 32'h55;
    @(negedge clk);
    check("zero_id_ready", 32'(bus.id_ready), 32'd1);
    tick;
    bus.id_valid = 1'b0;
    @(negedge clk);
    check("zero_we", 32'(bus.write_enable), 32'd0);
    check("zero_busy", 32'(bus.busy), 32'd0);
    check("zero_pending", 32'(bus.pending_mask), 32'h00);

    // Duplicate destination held under stall.
    tick;
    bus.wb_stall  = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 3'd4;
    bus.alu_value = 32'h10;
    expect_wr(1'b1, 3'd4, 32'h10);
    tick;
    bus.alu_value = 32'h20;
    expect_wr(1'b1, 3'd4, 32'h20);
    tick;
    bus.alu_valid = 1'b0;
    @(negedge clk);
    check("dup_pending", 32'(bus.pending_mask), 32'h10);
`ifdef WB_FORWARD_EN
    bus.fwd_addr = 3'd4;
    #1;
    check("fwd_hit", 32'(bus.fwd_hit), 32'd1);
    check("fwd_value", bus.fwd_value, 32'h20);
    bus.fwd_addr = 3'd0;
    #1;
    check("fwd_zero_miss", 32'(bus.fwd_hit), 32'd0);
`endif
    tick;
    bus.wb_stall = 1'b0;
    tick;
    @(negedge clk);
    check("dup_pending_one_left", 32'(bus.pending_mask), 32'h10);
    tick;
    @(negedge clk);
    check("dup_pending_clear", 32'(bus.pending_mask), 32'h00);
    check("dup_busy", 32'(bus.busy), 32'd0);

    repeat (2) tick;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
